wl_napot_demux: RTL



---
 rtl/wl_napot_demux.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wl_napot_demux.sv
// NAPOT address demultiplexer for the core-data reqrsp bus: one requester, NumPorts targets,
// in-order responses tracked by a small FIFO, local error responses for unmapped addresses.
package wl_napot_demux_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } core_data_req_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } core_data_rsp_chan_t;

    typedef struct packed {
        core_data_req_chan_t q;
        logic                q_valid;
        logic                p_ready;
    } core_data_req_t;

    typedef struct packed {
        core_data_rsp_chan_t p;
        logic                p_valid;
        logic                q_ready;
    } core_data_rsp_t;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] base;
        logic [31:0] mask;
    } addr_napot_demux_rule_t;
endpackage

module wl_napot_demux
    import wl_napot_demux_pkg::*;
#(
    parameter int unsigned NumPorts       = 4,
    parameter int unsigned NumRules       = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          DefaultPortEn  = 1'b0,
    parameter int unsigned DefaultPort    = 0,
    parameter int unsigned ErrCntWidth    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  addr_napot_demux_rule_t [NumRules-1:0] rules_i,
    input  core_data_req_t                        slv_req_i,
    output core_data_rsp_t                        slv_rsp_o,
    output core_data_req_t [NumPorts-1:0]         mst_req_o,
    input  core_data_rsp_t [NumPorts-1:0]         mst_rsp_i,
    output logic [ErrCntWidth-1:0]                err_cnt_o,
    output logic                                  busy_o
);

    localparam int unsigned TgtW = $clog2(NumPorts + 1);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;
    // Target index NumPorts stands for "no port": answered locally with an error.
    localparam logic [TgtW-1:0] ErrTgt  = TgtW'(NumPorts);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

    logic [TgtW-1:0]        tgt;
    logic                   matched;
    logic                   tgt_is_err;
    logic                   tgt_q_ready;
    logic [TgtW-1:0]        mem_q [MaxOutstanding];
    logic [TgtW-1:0]        mem_d [MaxOutstanding];
    logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
    logic                   full, empty, q_ready, p_valid, push, pop;
    logic [TgtW-1:0]        head;
    logic                   head_is_err, head_p_valid;
    core_data_rsp_chan_t    head_p;

    assign full        = (cnt_q == FullCnt);
    assign empty       = (cnt_q == '0);
    assign head        = mem_q[rptr_q];
    assign head_is_err = (head == ErrTgt);
    assign tgt_is_err  = (tgt == ErrTgt);

    // Address decode: lowest-index matching rule wins; out-of-range rule indices fall to ERR.
    always_comb begin
        tgt     = DefaultPortEn ? TgtW'(DefaultPort) : ErrTgt;
        matched = 1'b0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (!matched && ((slv_req_i.q.addr & rules_i[r].mask) ==
                             (rules_i[r].base & rules_i[r].mask))) begin
                matched = 1'b1;
                tgt     = (rules_i[r].idx < 32'(NumPorts)) ? TgtW'(rules_i[r].idx) : ErrTgt;
            end
        end
    end

    // Select the decoded target's q_ready and the FIFO head's response channel.
    always_comb begin
        tgt_q_ready  = 1'b0;
        head_p_valid = 1'b0;
        head_p       = '0;
        for (int unsigned t = 0; t < NumPorts; t++) begin
            if (tgt == TgtW'(t)) begin
                tgt_q_ready = mst_rsp_i[t].q_ready;
            end
            if (head == TgtW'(t)) begin
                head_p_valid = mst_rsp_i[t].p_valid;
                head_p       = mst_rsp_i[t].p;
            end
        end
    end

    // Request fan-out and response return; everything is forced idle while in reset.
    always_comb begin
        q_ready   = !rst_i && !full && (tgt_is_err || tgt_q_ready);
        p_valid   = 1'b0;
        slv_rsp_o = '0;
        if (!rst_i && !empty) begin
            if (head_is_err) begin
                p_valid             = 1'b1;
                slv_rsp_o.p.data    = '0;
                slv_rsp_o.p.error   = 1'b1;
            end else begin
                p_valid     = head_p_valid;
                slv_rsp_o.p = head_p;
            end
        end
        slv_rsp_o.q_ready = q_ready;
        slv_rsp_o.p_valid = p_valid;
        for (int unsigned t = 0; t < NumPorts; t++) begin
            mst_req_o[t].q       = slv_req_i.q;
            mst_req_o[t].q_valid = slv_req_i.q_valid && !rst_i && !full && (tgt == TgtW'(t));
            mst_req_o[t].p_ready = slv_req_i.p_ready && !rst_i && !empty && (head == TgtW'(t));
        end
    end

    assign push      = slv_req_i.q_valid && q_ready;
    assign pop       = p_valid && slv_req_i.p_ready;
    assign busy_o    = !rst_i && !empty;
    assign err_cnt_o = rst_i ? '0 : err_cnt_q;

    // Tracking FIFO and error counter next state.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            mem_d[wptr_q] = tgt;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push && tgt_is_err && (err_cnt_q != {ErrCntWidth{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset; in-flight entries are dropped on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule
